// File: rtl/connect4_pkg.sv
// Shared Connect-4 types and board geometry helpers.
// Used by the win checker and its line evaluator.
package connect4_pkg;

    localparam int ROWS    = 6;
    localparam int COLS    = 7;
    localparam int CONNECT = 4;
    localparam int CELLS   = ROWS * COLS;
    localparam int RW      = 3;
    localparam int CW      = 3;
    localparam int KW      = 6;

    typedef enum logic [1:0] {EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10} cell_t;
    typedef enum logic [1:0] {DIR_H, DIR_V, DIR_DR, DIR_DL} dir_t;

    typedef logic [ROWS-1:0][COLS-1:0][1:0] board_t;
    typedef logic [ROWS-1:0][COLS-1:0]      mask_t;

    function automatic int dir_dr(dir_t d);
        return (d == DIR_H) ? 0 : 1;
    endfunction

    function automatic int dir_dc(dir_t d);
        case (d)
            DIR_H:   return 1;
            DIR_V:   return 0;
            DIR_DR:  return 1;
            default: return -1;
        endcase
    endfunction

    function automatic logic in_range(int r, int c);
        return (r >= 0) && (r < ROWS) && (c >= 0) && (c < COLS);
    endfunction

    // Out-of-range coordinates read as empty so they can never complete a run.
    function automatic logic [1:0] cell_at(board_t b, int r, int c);
        logic [RW-1:0] ri;
        logic [CW-1:0] ci;
        ri = r[RW-1:0];
        ci = c[CW-1:0];
        if (in_range(r, c))
            return b[ri][ci];
        return 2'b00;
    endfunction

endpackage

// File: rtl/win_checker_line_eval.sv
// Decides whether CONNECT cells along one direction are all owned by one player.
// Returns 00 when the run is invalid, mixed, or contains empty/11 cells.
module line_eval
    import connect4_pkg::*;
(
    input  logic [CONNECT-1:0][1:0] cells,
    input  logic                    valid,
    output logic [1:0]              owner
);

    logic all_p1;
    logic all_p2;

    always_comb begin
        all_p1 = valid;
        all_p2 = valid;
        for (int i = 0; i < CONNECT; i++) begin
            all_p1 = all_p1 & (cells[i] == P1);
            all_p2 = all_p2 & (cells[i] == P2);
        end
        owner = all_p1 ? P1 : (all_p2 ? P2 : EMPTY);
    end

endmodule

// File: rtl/win_checker.sv
// Snapshots the board on start and scans one anchor per cycle for a four-in-a-row.
// Reports winner, draw and the winning cells as a mask.
//
//   state  | meaning
//   IDLE   | waiting for start; results held
//   SCAN   | evaluating anchor k = row*COLS + col
//   REPORT | one-cycle done pulse, then back to IDLE
module win_checker
    import connect4_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  board_t     tokens,
    input  logic       start,
    input  logic       newGame,
    output logic       busy,
    output logic       done,
    output logic [1:0] winner,
    output logic       draw,
    output mask_t      win_mask
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    localparam logic [KW-1:0] LAST_ANCHOR = KW'(CELLS - 1);
    localparam logic [KW-1:0] FULL_COUNT  = KW'(CELLS);
    localparam logic [CW-1:0] LAST_COL    = CW'(COLS - 1);

    state_t        state;
    board_t        board;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [KW-1:0] anchor;
    logic [KW-1:0] full_cnt;
    logic [KW-1:0] full_next;
    logic          anchor_full;

    logic [CONNECT-1:0][1:0] dir_cells [4];
    logic [3:0]              dir_valid;
    logic [1:0]              dir_owner [4];

    logic       win_hit;
    logic [1:0] win_owner;
    dir_t       win_dir;
    mask_t      hit_mask;

    always_comb begin
        for (int d = 0; d < 4; d++) begin
            dir_valid[d] = in_range(int'(row) + dir_dr(dir_t'(d)) * (CONNECT - 1),
                                    int'(col) + dir_dc(dir_t'(d)) * (CONNECT - 1));
            for (int i = 0; i < CONNECT; i++)
                dir_cells[d][i] = cell_at(board, int'(row) + dir_dr(dir_t'(d)) * i,
                                                 int'(col) + dir_dc(dir_t'(d)) * i);
        end
    end

    for (genvar d = 0; d < 4; d++) begin : g_dir
        line_eval u_eval (
            .cells (dir_cells[d]),
            .valid (dir_valid[d]),
            .owner (dir_owner[d])
        );
    end

    // Walking from DL down to H lets the highest-priority direction win the last write.
    always_comb begin
        int rr;
        int cc;
        win_hit   = 1'b0;
        win_owner = EMPTY;
        win_dir   = DIR_H;
        hit_mask  = '0;
        rr        = 0;
        cc        = 0;
        for (int d = 3; d >= 0; d--) begin
            if (dir_owner[d] != EMPTY) begin
                win_hit   = 1'b1;
                win_owner = dir_owner[d];
                win_dir   = dir_t'(d);
            end
        end
        for (int i = 0; i < CONNECT; i++) begin
            rr = int'(row) + dir_dr(win_dir) * i;
            cc = int'(col) + dir_dc(win_dir) * i;
            if (in_range(rr, cc))
                hit_mask[rr[RW-1:0]][cc[CW-1:0]] = 1'b1;
        end
    end

    assign anchor_full = (board[row][col] == P1) || (board[row][col] == P2);
    assign full_next   = full_cnt + KW'(anchor_full);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            board    <= '0;
            row      <= '0;
            col      <= '0;
            anchor   <= '0;
            full_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            winner   <= EMPTY;
            draw     <= 1'b0;
            win_mask <= '0;
        end else begin
            done <= 1'b0;
            if (newGame) begin
                state    <= IDLE;
                busy     <= 1'b0;
                draw     <= 1'b0;
                winner   <= EMPTY;
                win_mask <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            board    <= tokens;
                            winner   <= EMPTY;
                            draw     <= 1'b0;
                            win_mask <= '0;
                            row      <= '0;
                            col      <= '0;
                            anchor   <= '0;
                            full_cnt <= '0;
                            busy     <= 1'b1;
                            state    <= SCAN;
                        end
                    end
                    SCAN: begin
                        full_cnt <= full_next;
                        if (win_hit) begin
                            winner   <= win_owner;
                            win_mask <= hit_mask;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= REPORT;
                        end else if (anchor == LAST_ANCHOR) begin
                            draw  <= (full_next == FULL_COUNT);
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= REPORT;
                        end else begin
                            anchor <= anchor + 1'b1;
                            if (col == LAST_COL) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                    REPORT:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_win_checker.sv
// Directed bench for win_checker: table of boards with hand-computed results,
// plus sequences for mid-scan start, token changes, newGame and async reset.
module tb_win_checker;
    import connect4_pkg::*;

    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic       start   = 1'b0;
    logic       newGame = 1'b0;
    board_t     tokens  = '0;
    logic       busy;
    logic       done;
    logic [1:0] winner;
    logic       draw;
    mask_t      win_mask;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    win_checker dut (
        .clock    (clock),
        .reset    (reset),
        .tokens   (tokens),
        .start    (start),
        .newGame  (newGame),
        .busy     (busy),
        .done     (done),
        .winner   (winner),
        .draw     (draw),
        .win_mask (win_mask)
    );

    typedef struct {
        board_t     tok;
        logic [1:0] winner;
        logic       draw;
        mask_t      mask;
        int         lat;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic board_t put(board_t b, int r, int c, logic [1:0] v);
        logic [RW-1:0] ri;
        logic [CW-1:0] ci;
        ri = r[RW-1:0];
        ci = c[CW-1:0];
        b[ri][ci] = v;
        return b;
    endfunction

    function automatic mask_t mark(mask_t m, int r, int c);
        logic [RW-1:0] ri;
        logic [CW-1:0] ci;
        ri = r[RW-1:0];
        ci = c[CW-1:0];
        m[ri][ci] = 1'b1;
        return m;
    endfunction

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Returns done cycle relative to the start edge; busy must be 1 until done.
    task automatic wait_done(output int lat, output int busy_bad);
        int c;
        c = 1;
        busy_bad = 0;
        while (!done && c < 100) begin
            if (busy !== 1'b1) busy_bad++;
            @(negedge clock);
            c++;
        end
        if (busy !== 1'b0) busy_bad++;
        lat = c;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        board_t b;
        mask_t  m;
        int     lat;
        int     bb;
        int     c;
        logic   seen;

        // Empty board
        vecs[0] = '{'0, 2'b00, 1'b0, '0, 43};
        // P1 horizontal on the bottom row, anchor 35
        b = '0; m = '0;
        for (int i = 0; i < 4; i++) begin b = put(b, 5, i, 2'b01); m = mark(m, 5, i); end
        vecs[1] = '{b, 2'b01, 1'b0, m, 37};
        // P2 vertical in column 6 (anchor 20) beats the later bottom-row run
        b = '0; m = '0;
        for (int i = 0; i < 4; i++) begin
            b = put(b, 2 + i, 6, 2'b10); m = mark(m, 2 + i, 6);
            b = put(b, 5, 3 + i, 2'b10);
        end
        vecs[2] = '{b, 2'b10, 1'b0, m, 22};
        // P1 down-left diagonal from (2,3), anchor 17
        b = '0; m = '0;
        for (int i = 0; i < 4; i++) begin b = put(b, 2 + i, 3 - i, 2'b01); m = mark(m, 2 + i, 3 - i); end
        vecs[3] = '{b, 2'b01, 1'b0, m, 19};
        // Full board without any run: draw
        b = '0;
        for (int r = 0; r < ROWS; r++)
            for (int cc = 0; cc < COLS; cc++)
                b = put(b, r, cc, (((cc % 2) ^ ((r / 2) % 2)) == 0) ? 2'b01 : 2'b10);
        vecs[4] = '{b, 2'b00, 1'b1, '0, 43};
        // Same board with one 11 cell: not full
        b = put(b, 0, 0, 2'b11);
        vecs[5] = '{b, 2'b00, 1'b0, '0, 43};
        // P1 down-right diagonal at anchor 0
        b = '0; m = '0;
        for (int i = 0; i < 4; i++) begin b = put(b, i, i, 2'b01); m = mark(m, i, i); end
        vecs[6] = '{b, 2'b01, 1'b0, m, 2};
        // P2 H and V both from anchor 0: H has priority
        b = '0; m = '0;
        for (int i = 0; i < 4; i++) begin
            b = put(b, 0, i, 2'b10); m = mark(m, 0, i);
            b = put(b, i, 0, 2'b10);
        end
        vecs[7] = '{b, 2'b10, 1'b0, m, 2};
        // P2 down-left diagonal anchored at the right edge, anchor 6
        b = '0; m = '0;
        for (int i = 0; i < 4; i++) begin b = put(b, i, 6 - i, 2'b10); m = mark(m, i, 6 - i); end
        vecs[8] = '{b, 2'b10, 1'b0, m, 8};
        // Three P1 then a P2: no win
        b = '0;
        for (int i = 0; i < 3; i++) b = put(b, 0, i, 2'b01);
        b = put(b, 0, 3, 2'b10);
        vecs[9] = '{b, 2'b00, 1'b0, '0, 43};

        #1;
        check("reset_state", 64'({busy, done, winner, draw}), 64'(0));
        check("reset_mask", 64'(win_mask), 64'(0));
        @(negedge clock);
        reset = 1'b1;

        for (int v = 0; v < 10; v++) begin
            tokens = vecs[v].tok;
            pulse_start();
            wait_done(lat, bb);
            check($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].lat));
            check($sformatf("v%0d_busy", v), 64'(bb), 64'(0));
            check($sformatf("v%0d_winner", v), 64'(winner), 64'(vecs[v].winner));
            check($sformatf("v%0d_draw", v), 64'(draw), 64'(vecs[v].draw));
            check($sformatf("v%0d_mask", v), 64'(win_mask), 64'(vecs[v].mask));
            @(negedge clock);
            @(negedge clock);
            check($sformatf("v%0d_hold", v), 64'({winner, draw, win_mask}),
                  64'({vecs[v].winner, vecs[v].draw, vecs[v].mask}));
        end

        // Start at cycle 5 is ignored; tokens cleared at cycle 10 do not affect the snapshot
        tokens = vecs[1].tok;
        pulse_start();
        c = 1;
        while (!done && c < 100) begin
            @(negedge clock);
            c++;
            start = (c == 5);
            if (c == 10) tokens = '0;
        end
        start = 1'b0;
        check("mid_latency", 64'(c), 64'(37));
        check("mid_winner", 64'(winner), 64'(2'b01));
        check("mid_mask", 64'(win_mask), 64'(vecs[1].mask));
        @(negedge clock);
        @(negedge clock);
        check("mid_no_requeue", 64'(busy), 64'(0));

        // newGame clears held results
        tokens = vecs[6].tok;
        pulse_start();
        wait_done(lat, bb);
        check("ng_pre_winner", 64'(winner), 64'(2'b01));
        newGame = 1'b1;
        @(negedge clock);
        newGame = 1'b0;
        check("ng_clear", 64'({winner, draw, win_mask}), 64'(0));

        // newGame at cycle 20 aborts the scan with no done pulse
        tokens = '0;
        pulse_start();
        c = 1;
        while (c < 21) begin
            @(negedge clock);
            c++;
            if (c == 20) check("ng_busy_before", 64'(busy), 64'(1));
            newGame = (c == 20);
        end
        newGame = 1'b0;
        check("ng_busy_after", 64'(busy), 64'(0));
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done) seen = 1'b1;
        end
        check("ng_no_done", 64'(seen), 64'(0));

        // newGame wins over start in the same cycle
        start = 1'b1;
        newGame = 1'b1;
        @(negedge clock);
        start = 1'b0;
        newGame = 1'b0;
        check("ng_priority", 64'(busy), 64'(0));

        // Async reset at cycle 30 of a rescan clears outputs without a clock edge
        pulse_start();
        c = 1;
        while (c < 30) begin
            @(negedge clock);
            c++;
        end
        check("rst_busy_before", 64'(busy), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        check("rst_async", 64'({busy, done, winner, draw}), 64'(0));
        check("rst_mask", 64'(win_mask), 64'(0));
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_idle", 64'(busy), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/win_checker.md
Name: win_checker

Overview:
- Downstream game-logic stage for the Connect-4 design. It consumes the 6x7 board ownership array produced by the ownership stage.
- After each placed token (start pulse), it snapshots the board and scans it sequentially for four-in-a-row, horizontally, vertically or diagonally.
- It reports winner, draw and a per-cell win mask. The mask lets the colour stage highlight the winning line and lets the game controller lock further moves.

Parameters:
- ROWS, 6, board rows; row 0 is the top row.
- COLS, 7, board columns; column 0 is the leftmost column.
- CONNECT, 4, run length required to win.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- tokens  input  2 x [ROWS][COLS]  cell owner: 00 empty, 01 player 1, 10 player 2, 11 treated as empty
- start  input  1  single-cycle request to check the board
- newGame  input  1  synchronous clear; aborts any scan
- busy  output  1  scan in progress
- done  output  1  single-cycle pulse, result valid
- winner  output  2  00 none, 01 player 1, 10 player 2
- draw  output  1  board full with no winner
- win_mask  output  1 x [ROWS][COLS]  1 on each cell of the winning run

Behaviour:
- Reset (reset low, asynchronous): state IDLE; counters 0; busy, done, draw 0; winner 00; win_mask all 0. All take effect immediately, including mid-scan.
- States: IDLE, SCAN, REPORT.
- IDLE with start=1 at edge N:
  - snapshot tokens into internal board register;
  - clear winner, draw and win_mask;
  - set anchor index k=0 and full-cell count 0;
  - go to SCAN. busy=1 from cycle N+1.
- SCAN evaluates one anchor per cycle:
  - anchor k=r*COLS+c, raster order;
  - anchor k is evaluated in cycle N+1+k;
  - directions checked in parallel, in priority order: H (c..c+3), V (r..r+3), DR (r+i, c+i), DL (r+i, c-i);
  - a direction is valid only if every index stays in range;
  - a run wins if all 4 cells equal 01, or all 4 equal 10;
  - the full-cell counter (6 bits) increments when the anchor cell is 01 or 10.
- First win in SCAN:
  - latch winner and the mask of the highest-priority winning direction;
  - go to REPORT and stop scanning;
  - later anchors are not examined.
- No win at k=41: go to REPORT; draw=1 iff the final full count (including anchor 41) equals 42.
- REPORT, one cycle: done=1, busy=0; next state IDLE.
- Timing summary: win at anchor k gives done in cycle N+2+k; no win gives done in cycle N+43.
- winner, draw and win_mask hold until the next accepted start, newGame, or reset.
- start while in SCAN or REPORT: ignored, no queueing.
- Changes on tokens during a scan do not affect the result, because the scan uses the snapshot.
- newGame=1 at any edge:
  - next state IDLE;
  - busy, done, draw 0; winner 00; mask cleared;
  - has priority over start in the same cycle.
- Widths: row counter 3 bits, column counter 3 bits, anchor index 6 bits. Column wraps 6→0 with row increment; no wrap past k=41.

Decomposition:
- Shared package connect4_pkg holds:
  - typedef cell_t: EMPTY=2'b00, P1=2'b01, P2=2'b10;
  - constants ROWS, COLS, CONNECT;
  - enum dir_t {DIR_H, DIR_V, DIR_DR, DIR_DL};
  - the board typedef.
- One combinational sub-module, line_eval: takes CONNECT cells plus a valid bit, returns owner (00/01/10). Four instances, one per direction.
- FSM, counters, snapshot register and mask construction stay in win_checker.

Test Plan:
- Empty board, start at cycle 0 → busy cycles 1–42; done at cycle 43; winner 00, draw 0, mask all 0.
- P1 at row 5, cols 0–3 → anchor 35 wins H; done at cycle 37; winner 01; mask bits [5][0..3] set, all others 0.
- P2 at col 6, rows 2–5 (plus a P2 run at row 5, cols 3–6) → V win at anchor 20 found first; done at cycle 22; winner 10; mask shows the column run only.
- P1 diagonal (2,3),(3,2),(4,1),(5,0) → DL win at anchor 17; done at cycle 19; winner 01; exactly those four mask bits set.
- Full board in a column-alternating pattern with no four-in-a-row → done at cycle 43; winner 00, draw 1. The same board with one cell 11 → draw 0.
- Mid-scan stimulus:
  - start pulsed at cycle 5 → ignored;
  - tokens changed at cycle 10 → result equals the snapshot result;
  - newGame at cycle 20 → busy 0 at cycle 21, no done pulse;
  - reset low at cycle 30 of a rescan → outputs 0 immediately.
